// File: rtl/mem_access_unit.sv
// Load/store engine: decodes readMem/writeMem into one or two word-bus beats with byte strobes and load extension.
// Done pulses the cycle after the last bus_ack (or the cycle after accept on a rejected misalignment); the bus is held until it acks.
module mem_access_unit #(
  parameter int ADDR_W         = 32,
  parameter bit MISALIGN_SPLIT = 1'b1,
  parameter int TIMEOUT        = 0,
  parameter int TO_W           = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [2:0]        readMem,
  input  logic [1:0]        writeMem,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic [31:0]       rdata,
  output logic              misalign,
  output logic              bus_err,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_wstrb,
  output logic [31:0]       bus_wdata,
  input  logic [31:0]       bus_rdata,
  input  logic              bus_ack
);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  state_t            state, state_nxt;
  logic              st_store, st_sign, st_cross;
  logic [1:0]        st_size, st_off;
  logic [31:0]       st_wdata, beat0_rdata;
  logic [ADDR_W-1:0] st_base;
  logic [TO_W-1:0]   to_cnt;

  logic        dec_ok, dec_store, dec_sign, dec_mis, dec_cross;
  logic [1:0]  dec_size;
  logic [2:0]  dec_bytes;
  logic        accept, reject, timeout_hit;
  logic [3:0]  mask;
  logic [2:0]  hi_bytes;
  logic [63:0] ld_pair;
  logic [31:0] ld_lo, ld_word;

  // Size code: 0 byte, 1 half, 2 word; a nonzero writeMem overrides readMem.
  always_comb begin
    dec_ok    = 1'b1;
    dec_store = 1'b0;
    dec_sign  = 1'b0;
    dec_size  = 2'd0;
    if (writeMem != 2'b00) begin
      dec_store = 1'b1;
      dec_size  = writeMem - 2'd1;
    end else begin
      case (readMem)
        3'b001:  dec_size = 2'd2;
        3'b110:  begin dec_size = 2'd1; dec_sign = 1'b1; end
        3'b111:  begin dec_size = 2'd0; dec_sign = 1'b1; end
        3'b011:  dec_size = 2'd0;
        3'b010:  dec_size = 2'd1;
        default: dec_ok = 1'b0;
      endcase
    end
  end

  assign dec_bytes = (dec_size == 2'd0) ? 3'd1 : ((dec_size == 2'd1) ? 3'd2 : 3'd4);
  assign dec_mis   = ((dec_size == 2'd1) & addr[0]) | ((dec_size == 2'd2) & (addr[1:0] != 2'b00));
  assign dec_cross = ({1'b0, addr[1:0]} + dec_bytes) > 3'd4;
  assign accept    = (state == IDLE) & req_valid & dec_ok;
  assign reject    = accept & dec_mis & (MISALIGN_SPLIT == 1'b0);

  // An ack in the cycle the counter reaches its limit still wins.
  assign timeout_hit = (TIMEOUT != 0) && (state != IDLE) && !bus_ack && (to_cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && !reject) state_nxt = BEAT0;
      BEAT0:   if (bus_ack)          state_nxt = st_cross ? BEAT1 : IDLE;
               else if (timeout_hit) state_nxt = IDLE;
      BEAT1:   if (bus_ack || timeout_hit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign mask     = (st_size == 2'd0) ? 4'b0001 : ((st_size == 2'd1) ? 4'b0011 : 4'b1111);
  assign hi_bytes = 3'd4 - {1'b0, st_off};

  always_comb begin
    busy      = 1'b0;
    bus_req   = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = '0;
    bus_wstrb = 4'b0000;
    bus_wdata = 32'd0;
    case (state)
      BEAT0: begin
        busy     = 1'b1;
        bus_req  = 1'b1;
        bus_we   = st_store;
        bus_addr = st_base;
        if (st_store) begin
          bus_wstrb = mask << st_off;
          bus_wdata = st_wdata << {st_off, 3'b000};
        end
      end
      BEAT1: begin
        busy     = 1'b1;
        bus_req  = 1'b1;
        bus_we   = st_store;
        bus_addr = st_base + ADDR_W'(4);
        if (st_store) begin
          bus_wstrb = mask >> hi_bytes;
          bus_wdata = st_wdata >> {hi_bytes, 3'b000};
        end
      end
      default: ;
    endcase
  end

  // Single-beat loads see zero in the upper word, so one shifter covers both cases.
  assign ld_pair = (state == BEAT1) ? {bus_rdata, beat0_rdata} : {32'd0, bus_rdata};
  assign ld_lo   = 32'(ld_pair >> {st_off, 3'b000});

  always_comb begin
    case (st_size)
      2'd0:    ld_word = st_sign ? {{24{ld_lo[7]}}, ld_lo[7:0]} : {24'd0, ld_lo[7:0]};
      2'd1:    ld_word = st_sign ? {{16{ld_lo[15]}}, ld_lo[15:0]} : {16'd0, ld_lo[15:0]};
      default: ld_word = ld_lo;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      done        <= 1'b0;
      misalign    <= 1'b0;
      bus_err     <= 1'b0;
      rdata       <= 32'd0;
      st_store    <= 1'b0;
      st_sign     <= 1'b0;
      st_cross    <= 1'b0;
      st_size     <= 2'd0;
      st_off      <= 2'd0;
      st_wdata    <= 32'd0;
      st_base     <= '0;
      beat0_rdata <= 32'd0;
      to_cnt      <= '0;
    end else begin
      done     <= 1'b0;
      misalign <= 1'b0;
      bus_err  <= 1'b0;
      if (accept) begin
        st_store <= dec_store;
        st_sign  <= dec_sign;
        st_cross <= dec_cross;
        st_size  <= dec_size;
        st_off   <= addr[1:0];
        st_wdata <= wdata;
        st_base  <= {addr[ADDR_W-1:2], 2'b00};
        to_cnt   <= '0;
        if (reject) begin
          done     <= 1'b1;
          misalign <= 1'b1;
        end
      end
      if (state != IDLE) begin
        if (bus_ack) begin
          to_cnt <= '0;
          if (state == BEAT0) beat0_rdata <= bus_rdata;
          if ((state == BEAT1) || !st_cross) begin
            done <= 1'b1;
            if (!st_store) rdata <= ld_word;
          end
        end else if (timeout_hit) begin
          done    <= 1'b1;
          bus_err <= 1'b1;
          rdata   <= 32'd0;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: split/timeout instance against a byte-level memory model, plus a reject-misalign instance.
module tb_mem_access_unit;

  typedef struct {
    logic [2:0]  rm;
    logic [31:0] ad;
    logic [31:0] m0;
    logic [31:0] m1;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  strb;
    logic [31:0] wdata;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [2:0]  readMem = 3'b000;
  logic [1:0]  writeMem = 2'b00;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;

  logic        a_busy, a_done, a_misalign, a_bus_err, a_bus_req, a_bus_we;
  logic [31:0] a_rdata, a_bus_addr, a_bus_wdata;
  logic [3:0]  a_bus_wstrb;
  logic [31:0] a_bus_rdata = 32'd0;
  logic        a_bus_ack = 1'b0;

  logic        b_busy, b_done, b_misalign, b_bus_err, b_bus_req, b_bus_we;
  logic [31:0] b_rdata, b_bus_addr, b_bus_wdata;
  logic [3:0]  b_bus_wstrb;
  logic [31:0] b_bus_rdata = 32'd0;
  logic        b_bus_ack = 1'b0;

  int          tests = 0;
  int          fails = 0;
  int          ack_delay = 0;
  int          a_req_cycles = 0;
  int          b_req_cycles = 0;
  beat_t       blog[$];
  logic [31:0] mem [64];
  logic [7:0]  mref [256];
  logic [31:0] exp_last;
  logic        busy1, b_d1, b_m1, b_d2, b_m2;
  logic [31:0] b_r1, b_r2;
  vec_t        vt [11];
  logic [2:0]  ld_codes [5] = '{3'b001, 3'b110, 3'b111, 3'b011, 3'b010};
  logic [2:0]  inv_codes [3] = '{3'b000, 3'b100, 3'b101};

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(32), .MISALIGN_SPLIT(1'b1), .TIMEOUT(4), .TO_W(8)) u_a (
    .clk(clk), .rst(rst), .req_valid(req_valid), .readMem(readMem), .writeMem(writeMem),
    .addr(addr), .wdata(wdata), .busy(a_busy), .done(a_done), .rdata(a_rdata),
    .misalign(a_misalign), .bus_err(a_bus_err), .bus_req(a_bus_req), .bus_we(a_bus_we),
    .bus_addr(a_bus_addr), .bus_wstrb(a_bus_wstrb), .bus_wdata(a_bus_wdata),
    .bus_rdata(a_bus_rdata), .bus_ack(a_bus_ack));

  mem_access_unit #(.ADDR_W(32), .MISALIGN_SPLIT(1'b0), .TIMEOUT(0), .TO_W(8)) u_b (
    .clk(clk), .rst(rst), .req_valid(req_valid), .readMem(readMem), .writeMem(writeMem),
    .addr(addr), .wdata(wdata), .busy(b_busy), .done(b_done), .rdata(b_rdata),
    .misalign(b_misalign), .bus_err(b_bus_err), .bus_req(b_bus_req), .bus_we(b_bus_we),
    .bus_addr(b_bus_addr), .bus_wstrb(b_bus_wstrb), .bus_wdata(b_bus_wdata),
    .bus_rdata(b_bus_rdata), .bus_ack(b_bus_ack));

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask

  // Memory slave for instance A: acks after ack_delay wait cycles, checks held outputs.
  initial begin : slave_a
    int    wait_cnt;
    bit    pend;
    beat_t sv;
    int    idx;
    wait_cnt = 0;
    pend = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (a_bus_req === 1'b1) begin
        a_req_cycles++;
        if (pend) begin
          chk("stable_addr", a_bus_addr, sv.addr);
          chk("stable_ctl", 32'({a_bus_we, a_bus_wstrb}), 32'({sv.we, sv.strb}));
          chk("stable_wdata", a_bus_wdata, sv.wdata);
        end
        if (wait_cnt == ack_delay) begin
          idx = int'(a_bus_addr[7:2]);
          blog.push_back('{a_bus_addr, a_bus_we, a_bus_wstrb, a_bus_wdata});
          if (a_bus_we) begin
            for (int l = 0; l < 4; l++)
              if (a_bus_wstrb[l]) mem[idx][8*l +: 8] = a_bus_wdata[8*l +: 8];
          end else begin
            chk("read_strb_zero", 32'(a_bus_wstrb), 32'd0);
          end
          a_bus_rdata = mem[idx];
          a_bus_ack = 1'b1;
          wait_cnt = 0;
          pend = 1'b0;
        end else begin
          a_bus_ack = 1'b0;
          wait_cnt++;
          pend = 1'b1;
          sv = '{a_bus_addr, a_bus_we, a_bus_wstrb, a_bus_wdata};
        end
      end else begin
        a_bus_ack = 1'b0;
        wait_cnt = 0;
        pend = 1'b0;
      end
    end
  end

  initial begin : slave_b
    forever begin
      @(posedge clk); #1;
      b_bus_ack = (b_bus_req === 1'b1);
      b_bus_rdata = 32'h12345678;
      if (b_bus_req === 1'b1) b_req_cycles++;
    end
  end

  initial begin : watchdog
    #5ms;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1);
  end

  // One request on the shared inputs; returns at the first cycle A shows done (or a bounded wait).
  task automatic run_a(input logic [2:0] rm, input logic [1:0] wm, input logic [31:0] ad,
                       input logic [31:0] wd, output logic [31:0] rd, output logic mis,
                       output logic err, output int lat);
    blog.delete();
    a_req_cycles = 0;
    b_req_cycles = 0;
    req_valid = 1'b1; readMem = rm; writeMem = wm; addr = ad; wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    busy1 = a_busy; b_d1 = b_done; b_m1 = b_misalign; b_r1 = b_rdata;
    b_d2 = 1'b0; b_m2 = 1'b0; b_r2 = 32'd0;
    while (a_done !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 2) begin b_d2 = b_done; b_m2 = b_misalign; b_r2 = b_rdata; end
    end
    chk("done_seen", 32'(a_done), 32'd1);
    rd = a_rdata; mis = a_misalign; err = a_bus_err;
  endtask

  initial begin : main
    logic [31:0] rd, wd, ad, val;
    logic        mis, err, sgn, store;
    logic [2:0]  rm;
    logic [1:0]  wm;
    int          lat, size, beats, kind, w;

    vt[0]  = '{3'b001, 32'h0000_1000, 32'hDEADBEEF, 32'h0000_0000, 32'hDEADBEEF, 2};
    vt[1]  = '{3'b111, 32'h0000_1003, 32'h8000_0000, 32'h0000_0000, 32'hFFFFFF80, 2};
    vt[2]  = '{3'b011, 32'h0000_1003, 32'h8000_0000, 32'h0000_0000, 32'h0000_0080, 2};
    vt[3]  = '{3'b010, 32'h0000_1003, 32'hAB00_0000, 32'h0000_00CD, 32'h0000_CDAB, 3};
    vt[4]  = '{3'b110, 32'h0000_1001, 32'h0080_FF00, 32'h0000_0000, 32'hFFFF_80FF, 2};
    vt[5]  = '{3'b001, 32'h0000_1002, 32'h5566_7788, 32'h1122_3344, 32'h3344_5566, 3};
    vt[6]  = '{3'b001, 32'h0000_1003, 32'hAA00_0000, 32'h0011_2233, 32'h1122_33AA, 3};
    vt[7]  = '{3'b110, 32'h0000_1002, 32'h7FFF_0000, 32'h0000_0000, 32'h0000_7FFF, 2};
    vt[8]  = '{3'b111, 32'h0000_1000, 32'h0000_007F, 32'h0000_0000, 32'h0000_007F, 2};
    vt[9]  = '{3'b010, 32'h0000_1000, 32'h1234_FFFE, 32'h0000_0000, 32'h0000_FFFE, 2};
    vt[10] = '{3'b111, 32'h0000_1002, 32'h00F0_0000, 32'h0000_0000, 32'hFFFF_FFF0, 2};

    for (int i = 0; i < 64; i++) mem[i] = 32'd0;

    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_a_ctl", 32'({a_done, a_busy, a_misalign, a_bus_err, a_bus_req, a_bus_we, a_bus_wstrb}), 32'd0);
    chk("rst_a_addr", a_bus_addr, 32'd0);
    chk("rst_a_wdata", a_bus_wdata, 32'd0);
    chk("rst_a_rdata", a_rdata, 32'd0);
    chk("rst_b_ctl", 32'({b_done, b_busy, b_misalign, b_bus_err, b_bus_req, b_bus_wstrb}), 32'd0);
    rst = 1'b0;
    exp_last = 32'd0;

    // Directed loads
    for (int i = 0; i < 11; i++) begin
      ack_delay = 0;
      w = int'(vt[i].ad[7:2]);
      mem[w] = vt[i].m0;
      mem[(w + 1) % 64] = vt[i].m1;
      run_a(vt[i].rm, 2'b00, vt[i].ad, 32'd0, rd, mis, err, lat);
      chk($sformatf("vec%0d_rdata", i), rd, vt[i].exp);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vt[i].lat));
      chk($sformatf("vec%0d_busy", i), 32'(busy1), 32'd1);
      chk($sformatf("vec%0d_flags", i), 32'({mis, err}), 32'd0);
      exp_last = vt[i].exp;
    end

    // Split store with both codes driven: the write wins
    run_a(3'b001, 2'b11, 32'h0000_2002, 32'h1122_3344, rd, mis, err, lat);
    chk("sw_split_beats", 32'(blog.size()), 32'd2);
    chk("sw_split_latency", 32'(lat), 32'd3);
    chk("sw_rdata_held", rd, exp_last);
    if (blog.size() >= 2) begin
      chk("sw_b0_addr", blog[0].addr, 32'h0000_2000);
      chk("sw_b0_ctl", 32'({blog[0].we, blog[0].strb}), 32'b1_1100);
      chk("sw_b0_wdata", blog[0].wdata, 32'h3344_0000);
      chk("sw_b1_addr", blog[1].addr, 32'h0000_2004);
      chk("sw_b1_ctl", 32'({blog[1].we, blog[1].strb}), 32'b1_0011);
      chk("sw_b1_wdata", blog[1].wdata, 32'h0000_1122);
    end

    // Half store crossing the top of the address space
    run_a(3'b000, 2'b10, 32'hFFFF_FFFF, 32'h0000_BEEF, rd, mis, err, lat);
    chk("wrap_beats", 32'(blog.size()), 32'd2);
    chk("wrap_rdata_held", rd, exp_last);
    if (blog.size() >= 2) begin
      chk("wrap_b0_addr", blog[0].addr, 32'hFFFF_FFFC);
      chk("wrap_b0_strb", 32'(blog[0].strb), 32'b1000);
      chk("wrap_b0_wdata", blog[0].wdata, 32'hEF00_0000);
      chk("wrap_b1_addr", blog[1].addr, 32'h0000_0000);
      chk("wrap_b1_strb", 32'(blog[1].strb), 32'b0001);
      chk("wrap_b1_wdata", blog[1].wdata, 32'h0000_00BE);
    end

    // Watchdog expiry, then an ack on the last allowed cycle
    mem[0] = 32'hCAFE_F00D;
    ack_delay = 100;
    run_a(3'b001, 2'b00, 32'h0000_1000, 32'd0, rd, mis, err, lat);
    chk("to_req_cycles", 32'(a_req_cycles), 32'd4);
    chk("to_latency", 32'(lat), 32'd5);
    chk("to_flags", 32'({mis, err}), 32'b01);
    chk("to_rdata", rd, 32'd0);
    ack_delay = 3;
    run_a(3'b001, 2'b00, 32'h0000_1000, 32'd0, rd, mis, err, lat);
    chk("to_edge_latency", 32'(lat), 32'd5);
    chk("to_edge_flags", 32'({mis, err}), 32'b00);
    chk("to_edge_rdata", rd, 32'hCAFE_F00D);

    // Reject-misalign instance
    ack_delay = 0;
    mem[0] = 32'h1234_5678;
    run_a(3'b001, 2'b00, 32'h0000_1000, 32'd0, rd, mis, err, lat);
    chk("b_aligned_done", 32'({b_d1, b_d2}), 32'b01);
    chk("b_aligned_flags", 32'({b_m2, b_bus_err}), 32'd0);
    chk("b_aligned_rdata", b_r2, 32'h1234_5678);
    chk("b_aligned_reqs", 32'(b_req_cycles), 32'd1);
    run_a(3'b001, 2'b00, 32'h0000_1001, 32'd0, rd, mis, err, lat);
    chk("b_mis_done", 32'({b_d1, b_m1, b_d2, b_m2}), 32'b1100);
    chk("b_mis_reqs", 32'(b_req_cycles), 32'd0);
    chk("b_mis_rdata", b_r1, 32'h1234_5678);
    chk("a_split_flag", 32'(mis), 32'd0);

    // Reset while in the second beat
    req_valid = 1'b1; readMem = 3'b001; writeMem = 2'b00; addr = 32'h0000_1002;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("rst_beat1_req", 32'(a_bus_req), 32'd1);
    chk("rst_beat1_addr", a_bus_addr, 32'h0000_1004);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_ctl", 32'({a_done, a_busy, a_misalign, a_bus_err, a_bus_req, a_bus_we, a_bus_wstrb}), 32'd0);
    chk("rst_mid_addr", a_bus_addr, 32'd0);
    chk("rst_mid_wdata", a_bus_wdata, 32'd0);
    chk("rst_mid_rdata", a_rdata, 32'd0);
    rst = 1'b0;
    mem[0] = 32'h0BAD_CAFE;
    run_a(3'b001, 2'b00, 32'h0000_1000, 32'd0, rd, mis, err, lat);
    chk("post_rst_rdata", rd, 32'h0BAD_CAFE);
    chk("post_rst_latency", 32'(lat), 32'd2);
    exp_last = 32'h0BAD_CAFE;

    // Randomized traffic against a byte-addressed memory model
    for (int i = 0; i < 64; i++) begin
      mem[i] = $urandom;
      for (int l = 0; l < 4; l++) mref[4*i + l] = mem[i][8*l +: 8];
    end
    for (int n = 0; n < 400; n++) begin
      kind = int'($urandom_range(0, 9));
      ack_delay = int'($urandom_range(0, 3));
      ad = $urandom;
      wd = $urandom;
      if (kind == 0) begin
        req_valid = 1'b1; writeMem = 2'b00; readMem = inv_codes[$urandom_range(0, 2)];
        addr = ad; wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("invalid_ignored", 32'({a_busy, a_done, a_bus_req}), 32'd0);
      end else begin
        store = (kind < 5);
        sgn = 1'b0;
        if (store) begin
          wm = 2'($urandom_range(1, 3));
          rm = 3'($urandom_range(0, 7));
          size = (wm == 2'b11) ? 4 : int'(wm);
        end else begin
          wm = 2'b00;
          rm = ld_codes[$urandom_range(0, 4)];
          size = (rm == 3'b001) ? 4 : ((rm == 3'b110 || rm == 3'b010) ? 2 : 1);
          sgn = (rm == 3'b110 || rm == 3'b111);
        end
        beats = ((int'(ad[1:0]) + size) > 4) ? 2 : 1;
        val = 32'd0;
        for (int k = 0; k < size; k++) val[8*k +: 8] = mref[(int'(ad[7:0]) + k) % 256];
        if (sgn && size == 1 && val[7])  val = val | 32'hFFFF_FF00;
        if (sgn && size == 2 && val[15]) val = val | 32'hFFFF_0000;
        run_a(rm, wm, ad, wd, rd, mis, err, lat);
        if (store) begin
          for (int k = 0; k < size; k++) mref[(int'(ad[7:0]) + k) % 256] = wd[8*k +: 8];
        end else begin
          exp_last = val;
        end
        chk("rnd_rdata", rd, exp_last);
        chk("rnd_latency", 32'(lat), 32'(1 + beats * (1 + ack_delay)));
        chk("rnd_flags", 32'({mis, err}), 32'd0);
        chk("rnd_beats", 32'(blog.size()), 32'(beats));
        if (blog.size() >= 1) chk("rnd_b0_addr", blog[0].addr, ad & 32'hFFFF_FFFC);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
